// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES-CTR stream controller: block widths, the timeout default
// and the controller state encoding.
package aes_ctrl_pkg;

  localparam int unsigned AES_BLK_W              = 128;
  localparam int unsigned NONCE_W                = 96;
  localparam int unsigned CTR_W                  = 32;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 64;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StFull,
    StDrain
  } ctrl_state_e;

endpackage

// File: rtl/aes_ctr_out_reg.sv
// Single-entry valid/ready output register holding one CTR-mode result block.
module aes_ctr_out_reg
  import aes_ctrl_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 load_i,
  input  logic [AES_BLK_W-1:0] data_i,
  input  logic                 out_ready_i,
  output logic                 out_valid_o,
  output logic [AES_BLK_W-1:0] out_data_o
);

  logic                 valid_d, valid_q;
  logic [AES_BLK_W-1:0] data_d, data_q;

  // A reload in the same cycle as a consume keeps the register full.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/aes_ctr_stream_ctrl.sv
// CTR-mode initiator: issues counter blocks to the cipher wrapper one at a time, buffers the
// returned keystream and XORs it into a valid/ready plaintext stream.
module aes_ctr_stream_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int unsigned TO_WIDTH       = 7
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [NONCE_W-1:0]   nonce_i,
  input  logic [CTR_W-1:0]     ctr_init_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [AES_BLK_W-1:0] in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [AES_BLK_W-1:0] out_data_o,
  output logic                 aes_ld_o,
  output logic [AES_BLK_W-1:0] aes_text_in_o,
  input  logic                 aes_done_i,
  input  logic [AES_BLK_W-1:0] aes_text_buf_i,
  output logic                 busy_o,
  output logic                 err_timeout_o
);

  localparam logic [TO_WIDTH-1:0] TimerLast = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  ctrl_state_e          state_d, state_q;
  logic [NONCE_W-1:0]   nonce_d, nonce_q;
  logic [CTR_W-1:0]     ctr_d, ctr_q;
  logic [TO_WIDTH-1:0]  timer_d, timer_q;
  logic [AES_BLK_W-1:0] ks_buf_d, ks_buf_q;
  logic                 ks_valid_d, ks_valid_q;
  logic                 err_d, err_q;
  logic [AES_BLK_W-1:0] text_d, text_q;

  logic                 out_valid;
  logic                 in_ready;
  logic                 in_xfer;
  logic                 timer_last;
  logic                 flush;

  assign in_ready   = (state_q == StFull) & ks_valid_q & (~out_valid | out_ready_i) & ~start_i;
  assign in_xfer    = in_valid_i & in_ready;
  assign timer_last = (timer_q == TimerLast);

  always_comb begin
    state_d    = state_q;
    nonce_d    = nonce_q;
    ctr_d      = ctr_q;
    timer_d    = timer_q;
    ks_buf_d   = ks_buf_q;
    ks_valid_d = ks_valid_q;
    err_d      = err_q;
    text_d     = text_q;
    flush      = 1'b0;

    if (start_i) begin
      nonce_d    = nonce_i;
      ctr_d      = ctr_init_i;
      ks_valid_d = 1'b0;
      flush      = 1'b1;
      // A request is in flight from ISSUE onwards; its answer must be drained before the
      // next issue so that only one request is ever outstanding.
      if (state_q == StIssue || state_q == StWait || state_q == StDrain) begin
        state_d = StDrain;
        if (state_q == StIssue) begin
          timer_d = '0;
        end
      end else begin
        err_d   = 1'b0;
        state_d = StIssue;
      end
    end else begin
      unique case (state_q)
        StIdle: ;
        StIssue: begin
          timer_d = '0;
          state_d = StWait;
        end
        StWait: begin
          if (aes_done_i) begin
            ks_buf_d   = aes_text_buf_i;
            ks_valid_d = 1'b1;
            ctr_d      = ctr_q + CTR_W'(1);
            state_d    = StFull;
          end else if (timer_last) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            timer_d = timer_q + TO_WIDTH'(1);
          end
        end
        StFull: begin
          if (in_xfer) begin
            ks_valid_d = 1'b0;
            state_d    = StIssue;
          end
        end
        StDrain: begin
          if (aes_done_i || timer_last) begin
            state_d = StIssue;
          end else begin
            timer_d = timer_q + TO_WIDTH'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Counter block is registered on entry to ISSUE and held until the next issue.
    if (state_d == StIssue) begin
      text_d = {nonce_d, ctr_d};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      nonce_q    <= '0;
      ctr_q      <= '0;
      timer_q    <= '0;
      ks_buf_q   <= '0;
      ks_valid_q <= 1'b0;
      err_q      <= 1'b0;
      text_q     <= '0;
    end else begin
      state_q    <= state_d;
      nonce_q    <= nonce_d;
      ctr_q      <= ctr_d;
      timer_q    <= timer_d;
      ks_buf_q   <= ks_buf_d;
      ks_valid_q <= ks_valid_d;
      err_q      <= err_d;
      text_q     <= text_d;
    end
  end

  aes_ctr_out_reg u_out_reg (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush),
    .load_i      (in_xfer),
    .data_i      (in_data_i ^ ks_buf_q),
    .out_ready_i (out_ready_i),
    .out_valid_o (out_valid),
    .out_data_o  (out_data_o)
  );

  assign out_valid_o   = out_valid;
  assign in_ready_o    = in_ready;
  assign aes_ld_o      = (state_q == StIssue);
  assign aes_text_in_o = text_q;
  assign busy_o        = (state_q != StIdle);
  assign err_timeout_o = err_q;

endmodule

// File: tb/tb_aes_ctr_stream_ctrl.sv
// Bench for aes_ctr_stream_ctrl: a latency-programmable cipher stub returning ~text_in and a
// block-level CTR model (out[i] = in[i] ^ ~{nonce, ctr_init + i}).
module tb_aes_ctr_stream_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [95:0]  nonce = '0;
  logic [31:0]  ctr_init = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         aes_ld;
  logic [127:0] aes_text_in;
  logic         aes_done = 1'b0;
  logic [127:0] aes_text_buf = '0;
  logic         busy;
  logic         err_timeout;

  int total = 0;
  int bad = 0;

  // Stub controls (written by tests) and stub state (written by the stub only).
  bit           stub_mode = 1'b0;
  bit           stub_keep = 1'b0;
  int           stub_lat = 10;
  int           stub_cnt = 0;
  logic [127:0] stub_text = '0;

  aes_ctr_stream_ctrl #(
    .TIMEOUT_CYCLES (64),
    .TO_WIDTH       (7)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .nonce_i        (nonce),
    .ctr_init_i     (ctr_init),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_data_i      (in_data),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_data_o     (out_data),
    .aes_ld_o       (aes_ld),
    .aes_text_in_o  (aes_text_in),
    .aes_done_i     (aes_done),
    .aes_text_buf_i (aes_text_buf),
    .busy_o         (busy),
    .err_timeout_o  (err_timeout)
  );

  always #5 clk = ~clk;

  // Cipher stub: done pulses stub_lat cycles after the cycle in which aes_ld is seen.
  always begin
    @(posedge clk);
    #1;
    aes_done = 1'b0;
    if (!rst_n && !stub_keep) stub_cnt = 0;
    if (stub_cnt > 0) begin
      stub_cnt = stub_cnt - 1;
      if (stub_cnt == 0) begin
        aes_done     = 1'b1;
        aes_text_buf = ~stub_text;
      end
    end
    if (rst_n && aes_ld && stub_mode) begin
      stub_text = aes_text_in;
      stub_cnt  = stub_lat;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    nonce     = '0;
    ctr_init  = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse_start(input logic [95:0] n, input logic [31:0] c);
    @(posedge clk);
    #1;
    start    = 1'b1;
    nonce    = n;
    ctr_init = c;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    total += 7;
    if (aes_ld !== 1'b0) begin bad++; $display("FAIL %s aes_ld: got %b want 0", tag, aes_ld); end
    if (aes_text_in !== 128'd0) begin
      bad++; $display("FAIL %s aes_text_in: got %h want 0", tag, aes_text_in);
    end
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL %s out_valid: got %b want 0", tag, out_valid);
    end
    if (out_data !== 128'd0) begin
      bad++; $display("FAIL %s out_data: got %h want 0", tag, out_data);
    end
    if (in_ready !== 1'b0) begin bad++; $display("FAIL %s in_ready: got %b want 0", tag, in_ready); end
    if (busy !== 1'b0) begin bad++; $display("FAIL %s busy: got %b want 0", tag, busy); end
    if (err_timeout !== 1'b0) begin
      bad++; $display("FAIL %s err_timeout: got %b want 0", tag, err_timeout);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    check_reset_values("reset");
  endtask

  // Streams n blocks through the DUT with random gaps/backpressure and checks every issued
  // counter block and every output block against the CTR model.
  task automatic run_stream(input logic [95:0] n_val, input logic [31:0] c_val, input int n,
                            input bit zero_data, input int max_gap, input int rdy_pct,
                            input string tag);
    logic [127:0] exp_q[$];
    bit           fin;
    int           n_out;
    fin   = 1'b0;
    n_out = 0;
    do_reset();
    stub_mode = 1'b1;
    stub_lat  = 10;
    pulse_start(n_val, c_val);
    fork
      begin : driver
        logic [127:0] d;
        int           c;
        for (int i = 0; i < n; i++) begin
          d = zero_data ? 128'd0 : {$urandom, $urandom, $urandom, $urandom};
          exp_q.push_back(d ^ ~{n_val, c_val + 32'(i)});
          in_data  = d;
          in_valid = 1'b1;
          c = 0;
          do begin @(negedge clk); c++; end while (!in_ready && c < 200);
          if (!in_ready) begin
            total++; bad++;
            $display("FAIL %s in_ready timeout at block %0d: got 0 want 1", tag, i);
            break;
          end
          @(posedge clk);
          #1 in_valid = 1'b0;
          repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
        end
      end
      begin : monitor
        logic [127:0] e;
        int           c;
        c = 0;
        while (n_out < n && c < n * 200) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(99, 0) < rdy_pct);
          @(negedge clk);
          c++;
          if (out_valid && out_ready) begin
            e = exp_q.pop_front();
            total++;
            if (out_data !== e) begin
              bad++; $display("FAIL %s out_data[%0d]: got %h want %h", tag, n_out, out_data, e);
            end
            n_out++;
          end
        end
        fin = 1'b1;
      end
      begin : ld_watch
        logic [127:0] et;
        int           n_ld;
        bit           prev;
        n_ld = 0;
        prev = 1'b0;
        while (!fin) begin
          @(negedge clk);
          if (aes_ld) begin
            et = {n_val, c_val + 32'(n_ld)};
            total += 2;
            if (aes_text_in !== et) begin
              bad++; $display("FAIL %s text_in[%0d]: got %h want %h", tag, n_ld, aes_text_in, et);
            end
            if (prev) begin
              bad++; $display("FAIL %s aes_ld back-to-back: got 1 want 0", tag);
            end
            n_ld++;
          end
          prev = aes_ld;
        end
      end
    join
    total++;
    if (n_out != n) begin bad++; $display("FAIL %s block count: got %0d want %0d", tag, n_out, n); end
    out_ready = 1'b0;
  endtask

  task automatic test_basic();
    run_stream(96'd0, 32'hFFFF_FFFF, 2, 1'b1, 0, 100, "basic");
  endtask

  task automatic test_random();
    run_stream({$urandom, $urandom, $urandom}, 32'hFFFF_FFFE, 6, 1'b0, 2, 60, "rand_wrap");
    for (int k = 0; k < 2; k++) begin
      run_stream({$urandom, $urandom, $urandom}, $urandom, 6, 1'b0, 3, 50, "rand");
    end
  endtask

  task automatic test_back_to_back();
    run_stream({$urandom, $urandom, $urandom}, $urandom, 8, 1'b0, 0, 100, "b2b");
  endtask

  task automatic test_backpressure();
    logic [95:0]  nn;
    logic [31:0]  cc;
    logic [127:0] d0, d1, e0, e1;
    int           lds, c;
    bit           rdy_seen;
    lds = 0;
    rdy_seen = 1'b0;
    do_reset();
    stub_mode = 1'b1;
    stub_lat  = 6;
    nn = {$urandom, $urandom, $urandom};
    cc = $urandom;
    d0 = {$urandom, $urandom, $urandom, $urandom};
    d1 = {$urandom, $urandom, $urandom, $urandom};
    e0 = d0 ^ ~{nn, cc};
    e1 = d1 ^ ~{nn, cc + 32'd1};
    pulse_start(nn, cc);
    in_valid = 1'b1;
    in_data  = d0;
    c = 0;
    do begin @(negedge clk); c++; if (aes_ld) lds++; end while (!in_ready && c < 100);
    total++;
    if (!in_ready) begin bad++; $display("FAIL bp first in_ready: got 0 want 1"); end
    @(posedge clk);
    #1 in_data = d1;
    repeat (40) begin
      @(negedge clk);
      if (aes_ld) lds++;
      if (in_ready) rdy_seen = 1'b1;
    end
    total += 4;
    if (lds != 2) begin bad++; $display("FAIL bp ld count: got %0d want 2", lds); end
    if (rdy_seen) begin bad++; $display("FAIL bp in_ready while blocked: got 1 want 0"); end
    if (out_valid !== 1'b1) begin bad++; $display("FAIL bp held out_valid: got %b want 1", out_valid); end
    if (out_data !== e0) begin bad++; $display("FAIL bp held out_data: got %h want %h", out_data, e0); end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    total += 2;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp release in_ready: got %b want 1", in_ready); end
    if (out_data !== e0) begin bad++; $display("FAIL bp block0: got %h want %h", out_data, e0); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    total += 2;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL bp block1 valid: got %b want 1", out_valid); end
    if (out_data !== e1) begin bad++; $display("FAIL bp block1: got %h want %h", out_data, e1); end
    @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL bp drained valid: got %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int c, n;
    do_reset();
    stub_mode = 1'b0;
    pulse_start({$urandom, $urandom, $urandom}, $urandom);
    c = 0;
    do begin @(negedge clk); c++; end while (!aes_ld && c < 10);
    total++;
    if (!aes_ld) begin bad++; $display("FAIL timeout aes_ld: got 0 want 1"); end
    @(posedge clk);  // edge at which the cipher samples aes_ld
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!err_timeout && n < 200);
    total += 2;
    if (n != 64) begin bad++; $display("FAIL timeout latency: got %0d want 64", n); end
    if (busy !== 1'b0) begin bad++; $display("FAIL timeout busy: got %b want 0", busy); end
    repeat (3) @(negedge clk);
    total++;
    if (err_timeout !== 1'b1) begin bad++; $display("FAIL timeout sticky: got %b want 1", err_timeout); end
    stub_mode = 1'b1;
    pulse_start({$urandom, $urandom, $urandom}, $urandom);
    @(negedge clk);
    total += 2;
    if (err_timeout !== 1'b0) begin
      bad++; $display("FAIL timeout clear: got %b want 0", err_timeout);
    end
    if (aes_ld !== 1'b1) begin bad++; $display("FAIL timeout restart ld: got %b want 1", aes_ld); end
  endtask

  task automatic test_abort();
    logic [31:0]  c2;
    logic [127:0] d, e;
    bit           seen, stale, early;
    int           c;
    seen = 1'b0; stale = 1'b0; early = 1'b0;
    do_reset();
    stub_mode = 1'b1;
    stub_lat  = 8;
    out_ready = 1'b1;
    c2 = $urandom;
    pulse_start({$urandom, $urandom, $urandom}, $urandom);
    @(negedge clk);
    total++;
    if (aes_ld !== 1'b1) begin bad++; $display("FAIL abort first ld: got %b want 1", aes_ld); end
    repeat (3) begin @(posedge clk); #1; end
    start    = 1'b1;
    nonce    = 96'd1;
    ctr_init = c2;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (in_ready && !seen) early = 1'b1;
      if (out_valid) stale = 1'b1;
      if (aes_ld && !seen) begin
        seen = 1'b1;
        total++;
        if (aes_text_in !== {96'd1, c2}) begin
          bad++; $display("FAIL abort new text_in: got %h want %h", aes_text_in, {96'd1, c2});
        end
      end
    end
    total += 3;
    if (!seen) begin bad++; $display("FAIL abort reissue: got 0 want 1"); end
    if (stale) begin bad++; $display("FAIL abort stale out_valid: got 1 want 0"); end
    if (early) begin bad++; $display("FAIL abort in_ready before reissue: got 1 want 0"); end
    d = {$urandom, $urandom, $urandom, $urandom};
    e = d ^ ~{96'd1, c2};
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    c = 0;
    do begin @(negedge clk); c++; end while (!in_ready && c < 50);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    total += 2;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL abort out_valid: got %b want 1", out_valid); end
    if (out_data !== e) begin bad++; $display("FAIL abort out_data: got %h want %h", out_data, e); end
    out_ready = 1'b0;
  endtask

  task automatic test_boundary();
    int c;
    do_reset();
    stub_mode = 1'b1;
    stub_lat  = 64;
    out_ready = 1'b1;
    pulse_start({$urandom, $urandom, $urandom}, $urandom);
    c = 0;
    do begin @(negedge clk); c++; end while (!aes_ld && c < 10);
    c = 0;
    do begin @(negedge clk); c++; end while (!aes_done && c < 100);
    total++;
    if (c != 64) begin bad++; $display("FAIL boundary done offset: got %0d want 64", c); end
    @(negedge clk);
    total += 3;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL boundary ks_valid: got %b want 1", in_ready); end
    if (err_timeout !== 1'b0) begin
      bad++; $display("FAIL boundary err_timeout: got %b want 0", err_timeout);
    end
    if (busy !== 1'b1) begin bad++; $display("FAIL boundary busy: got %b want 1", busy); end
    // One cycle later the timeout wins and the late done is ignored.
    do_reset();
    stub_mode = 1'b1;
    stub_lat  = 65;
    out_ready = 1'b1;
    pulse_start({$urandom, $urandom, $urandom}, $urandom);
    repeat (72) @(negedge clk);
    total += 3;
    if (err_timeout !== 1'b1) begin
      bad++; $display("FAIL late done err_timeout: got %b want 1", err_timeout);
    end
    if (in_ready !== 1'b0) begin bad++; $display("FAIL late done in_ready: got %b want 0", in_ready); end
    if (busy !== 1'b0) begin bad++; $display("FAIL late done busy: got %b want 0", busy); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    int  c;
    bit  activity;
    activity = 1'b0;
    do_reset();
    stub_mode = 1'b1;
    stub_keep = 1'b1;
    stub_lat  = 10;
    out_ready = 1'b1;
    pulse_start({$urandom, $urandom, $urandom}, $urandom);
    c = 0;
    do begin @(negedge clk); c++; end while (!aes_ld && c < 10);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_values("reset_mid_wait");
    @(posedge clk);
    #1 rst_n = 1'b1;
    in_valid = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (aes_ld || out_valid || in_ready || busy) activity = 1'b1;
    end
    total++;
    if (activity) begin bad++; $display("FAIL late done after reset: got activity want none"); end
    in_valid  = 1'b0;
    stub_keep = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_abort();
    test_boundary();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
